// File: rtl/pe_cfg_pkg.sv
// Shared definitions for the PE configuration loader: header field layout and FSM states.
package pe_cfg_pkg;

    localparam int unsigned CFG_W    = 32;
    localparam int unsigned FIELD_W  = 8;
    localparam int unsigned PE_ID_HI = 31;
    localparam int unsigned PE_ID_LO = 24;
    localparam int unsigned COUNT_HI = 23;
    localparam int unsigned COUNT_LO = 16;

    typedef enum logic [2:0] {
        IDLE,
        HEADER,
        PAYLOAD,
        DRAIN,
        DONE
    } state_e;

endpackage

// File: rtl/pe_config_loader_if.sv
// Host word stream into the loader: valid/ready handshake with a CFG_W-bit word.
interface pe_config_loader_if #(
    parameter int unsigned CFG_W = pe_cfg_pkg::CFG_W
) ();

    logic             cfg_in_valid;
    logic [CFG_W-1:0] cfg_in_data;
    logic             cfg_in_ready;

    modport master (
        output cfg_in_valid,
        output cfg_in_data,
        input  cfg_in_ready
    );

    modport slave (
        input  cfg_in_valid,
        input  cfg_in_data,
        output cfg_in_ready
    );

endinterface

// File: rtl/pe_cfg_demux.sv
// Combinational steering of one payload word onto the selected PE slice; other slices stay zero.
module pe_cfg_demux #(
    parameter int unsigned NUM_PE = 2,
    parameter int unsigned CFG_W  = 32,
    parameter int unsigned ID_W   = 8
) (
    input  logic                        valid,
    input  logic [ID_W-1:0]             pe_id,
    input  logic [CFG_W-1:0]            word,
    output logic [NUM_PE*(CFG_W+1)-1:0] slices
);

    localparam int unsigned SLICE_W = CFG_W + 1;

    always_comb begin
        slices = '0;
        for (int unsigned i = 0; i < NUM_PE; i++) begin
            if (valid && (32'(pe_id) == i)) begin
                slices[i*SLICE_W +: SLICE_W] = {1'b1, word};
            end
        end
    end

endmodule

// File: rtl/pe_config_loader.sv
// Parses a header/payload word stream and pulses each payload word onto one PE configure port.
module pe_config_loader #(
    parameter int unsigned NUM_PE    = 2,
    parameter int unsigned CFG_W     = pe_cfg_pkg::CFG_W,
    parameter int unsigned MAX_WORDS = 4
) (
    input  logic                        clk,
    input  logic                        reset,
    input  logic                        start,
    pe_config_loader_if.slave           cfg,
    output logic [NUM_PE*(CFG_W+1)-1:0] PE_Configure_Outport,
    output logic                        busy,
    output logic                        done,
    output logic                        error
);

    import pe_cfg_pkg::*;

    localparam int unsigned OUT_W = NUM_PE * (CFG_W + 1);

    state_e             state_q, state_d;
    logic [FIELD_W-1:0] remaining_q, remaining_d;
    logic [FIELD_W-1:0] pe_id_q, pe_id_d;
    logic               error_d;
    logic               ready_q, ready_d;
    logic               busy_d, done_d;
    logic               pulse_c;
    logic               accept_c;
    logic [FIELD_W-1:0] hdr_pe_id_c, hdr_count_c;
    logic [OUT_W-1:0]   slices_c;

    assign accept_c         = cfg.cfg_in_valid && ready_q;
    assign hdr_pe_id_c      = cfg.cfg_in_data[PE_ID_HI:PE_ID_LO];
    assign hdr_count_c      = cfg.cfg_in_data[COUNT_HI:COUNT_LO];
    assign cfg.cfg_in_ready = ready_q;

    // Next-state and registered-output decode; ready/busy/done follow the next state only.
    always_comb begin
        state_d     = state_q;
        remaining_d = remaining_q;
        pe_id_d     = pe_id_q;
        error_d     = error;
        pulse_c     = 1'b0;

        unique case (state_q)
            IDLE: begin
                if (start) begin
                    error_d = 1'b0;
                    state_d = HEADER;
                end
            end
            HEADER: begin
                if (accept_c) begin
                    if (hdr_count_c == '0) begin
                        state_d = DONE;
                    end else if ((32'(hdr_pe_id_c) >= NUM_PE) || (32'(hdr_count_c) > MAX_WORDS)) begin
                        error_d     = 1'b1;
                        remaining_d = hdr_count_c;
                        state_d     = DRAIN;
                    end else begin
                        pe_id_d     = hdr_pe_id_c;
                        remaining_d = hdr_count_c;
                        state_d     = PAYLOAD;
                    end
                end
            end
            PAYLOAD: begin
                if (accept_c) begin
                    pulse_c = 1'b1;
                    if (remaining_q != '0) remaining_d = remaining_q - FIELD_W'(1);
                    if (remaining_q <= FIELD_W'(1)) state_d = HEADER;
                end
            end
            DRAIN: begin
                // Bad header: swallow its payload so the stream stays aligned to the next header.
                if (remaining_q == '0) begin
                    state_d = HEADER;
                end else if (accept_c) begin
                    remaining_d = remaining_q - FIELD_W'(1);
                    if (remaining_q == FIELD_W'(1)) state_d = HEADER;
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        ready_d = (state_d == HEADER) || (state_d == PAYLOAD) || (state_d == DRAIN);
        busy_d  = (state_d != IDLE);
        done_d  = (state_d == DONE);
    end

    pe_cfg_demux #(
        .NUM_PE (NUM_PE),
        .CFG_W  (CFG_W),
        .ID_W   (FIELD_W)
    ) u_demux (
        .valid  (pulse_c),
        .pe_id  (pe_id_q),
        .word   (cfg.cfg_in_data),
        .slices (slices_c)
    );

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q              <= IDLE;
            remaining_q          <= '0;
            pe_id_q              <= '0;
            error                <= 1'b0;
            ready_q              <= 1'b0;
            busy                 <= 1'b0;
            done                 <= 1'b0;
            PE_Configure_Outport <= '0;
        end else begin
            state_q              <= state_d;
            remaining_q          <= remaining_d;
            pe_id_q              <= pe_id_d;
            error                <= error_d;
            ready_q              <= ready_d;
            busy                 <= busy_d;
            done                 <= done_d;
            PE_Configure_Outport <= slices_c;
        end
    end

endmodule

// File: tb/tb_pe_config_loader.sv
// Randomized self-checking bench for pe_config_loader against a stream-level reference model.
module tb_pe_config_loader;

    localparam int unsigned NUM_PE    = 2;
    localparam int unsigned CFG_W     = 32;
    localparam int unsigned MAX_WORDS = 4;
    localparam int unsigned SLICE_W   = CFG_W + 1;
    localparam int unsigned OUT_W     = NUM_PE * SLICE_W;

    logic             clk = 1'b0;
    logic             reset;
    logic             start;
    logic [OUT_W-1:0] pe_out;
    logic             busy;
    logic             done;
    logic             error;

    pe_config_loader_if #(.CFG_W(CFG_W)) cfg_bus ();

    pe_config_loader #(
        .NUM_PE    (NUM_PE),
        .CFG_W     (CFG_W),
        .MAX_WORDS (MAX_WORDS)
    ) dut (
        .clk                  (clk),
        .reset                (reset),
        .start                (start),
        .cfg                  (cfg_bus),
        .PE_Configure_Outport (pe_out),
        .busy                 (busy),
        .done                 (done),
        .error                (error)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_bad = 0;

    // Reference model: words still owed to the current header, their target (-1 = discard), sticky error.
    int          m_left;
    int          m_target;
    bit          m_err;
    logic [31:0] stim[$];

    function automatic logic [31:0] hdr(input int pe, input int cnt);
        return {8'(pe), 8'(cnt), 16'h0000};
    endfunction

    task automatic push_random_program(input int n_hdr);
        int pe;
        int cnt;
        for (int k = 0; k < n_hdr; k++) begin
            pe  = $urandom_range(0, 3);
            cnt = $urandom_range(1, 6);
            stim.push_back(hdr(pe, cnt));
            for (int j = 0; j < cnt; j++) stim.push_back($urandom);
        end
        stim.push_back(hdr(0, 0));
    endtask

    task automatic start_load();
        start = 1'b1;
        @(posedge clk); #1;
        start    = 1'b0;
        m_left   = 0;
        m_target = -1;
        m_err    = 1'b0;
        n_cmp++;
        if (busy !== 1'b1 || cfg_bus.cfg_in_ready !== 1'b1 || error !== 1'b0 || done !== 1'b0) begin
            n_bad++;
            $display("FAIL start_load: busy/ready/error/done got %b%b%b%b expected 1100",
                     busy, cfg_bus.cfg_in_ready, error, done);
        end
    endtask

    // Drives stim through the handshake and checks every cycle's outputs against the model.
    task automatic run_stream(input int valid_mode, input bit start_noise);
        int               idx;
        int               cyc;
        bit               toggle;
        bit               fin;
        bit               v;
        bit               end_seen;
        int               pe;
        int               cnt;
        logic [31:0]      w;
        logic [OUT_W-1:0] exp_out;
        idx = 0; cyc = 0; toggle = 1'b1; fin = 1'b0;
        while (!fin && cyc < 2000) begin
            v = (idx < stim.size()) &&
                ((valid_mode == 0) || (valid_mode == 1 && toggle) ||
                 (valid_mode == 2 && $urandom_range(0, 2) != 0));
            toggle = ~toggle;
            cfg_bus.cfg_in_valid = v;
            cfg_bus.cfg_in_data  = v ? stim[idx] : $urandom;
            start = start_noise;
            n_cmp++;
            if (cfg_bus.cfg_in_ready !== 1'b1 || busy !== 1'b1) begin
                n_bad++;
                $display("FAIL loading_ready_busy: got %b%b expected 11", cfg_bus.cfg_in_ready, busy);
            end
            @(posedge clk); #1;
            cyc++;
            exp_out  = '0;
            end_seen = 1'b0;
            if (v) begin
                w = stim[idx];
                idx++;
                if (m_left == 0) begin
                    pe  = int'(w[31:24]);
                    cnt = int'(w[23:16]);
                    if (cnt == 0) begin
                        end_seen = 1'b1;
                    end else if (pe >= int'(NUM_PE) || cnt > int'(MAX_WORDS)) begin
                        m_err    = 1'b1;
                        m_left   = cnt;
                        m_target = -1;
                    end else begin
                        m_left   = cnt;
                        m_target = pe;
                    end
                end else begin
                    if (m_target >= 0) exp_out[m_target*SLICE_W +: SLICE_W] = {1'b1, w};
                    m_left--;
                end
            end
            n_cmp++;
            if (pe_out !== exp_out) begin
                n_bad++;
                $display("FAIL slice_pulse word %0d: got %h expected %h", idx, pe_out, exp_out);
            end
            n_cmp++;
            if (error !== m_err || done !== end_seen) begin
                n_bad++;
                $display("FAIL error_done: got %b%b expected %b%b", error, done, m_err, end_seen);
            end
            if (end_seen) begin
                cfg_bus.cfg_in_valid = 1'b0;
                @(posedge clk); #1;
                start = 1'b0;
                fin   = 1'b1;
                n_cmp++;
                if (done !== 1'b0 || busy !== 1'b0 || cfg_bus.cfg_in_ready !== 1'b0 || pe_out !== '0) begin
                    n_bad++;
                    $display("FAIL back_to_idle: done/busy/ready got %b%b%b out %h expected 000 out 0",
                             done, busy, cfg_bus.cfg_in_ready, pe_out);
                end
            end
        end
        start = 1'b0;
        cfg_bus.cfg_in_valid = 1'b0;
        stim.delete();
        n_cmp++;
        if (!fin) begin
            n_bad++;
            $display("FAIL stream_timeout: got no end of program after %0d cycles, expected done", cyc);
        end
    endtask

    task automatic test_reset();
        reset = 1'b1;
        #1 reset = 1'b0;
        #1;
        n_cmp++;
        if (pe_out !== '0 || cfg_bus.cfg_in_ready !== 1'b0 || busy !== 1'b0 || done !== 1'b0 || error !== 1'b0) begin
            n_bad++;
            $display("FAIL reset_values: out %h ready/busy/done/error %b%b%b%b expected all 0",
                     pe_out, cfg_bus.cfg_in_ready, busy, done, error);
        end
        repeat (2) @(posedge clk);
        #1 reset = 1'b1;
        @(posedge clk); #1;
        n_cmp++;
        if (busy !== 1'b0 || cfg_bus.cfg_in_ready !== 1'b0) begin
            n_bad++;
            $display("FAIL idle_after_reset: busy/ready got %b%b expected 00", busy, cfg_bus.cfg_in_ready);
        end
    endtask

    task automatic test_basic();
        start_load();
        stim = '{hdr(0, 2), 32'h0000_0000, 32'h0000_0005, hdr(1, 1), 32'h0000_0002, hdr(0, 0)};
        run_stream(0, 1'b0);
        n_cmp++;
        if (error !== 1'b0) begin
            n_bad++;
            $display("FAIL basic_error: got %b expected 0", error);
        end
    endtask

    task automatic test_bad_pe();
        start_load();
        stim = '{hdr(3, 2), 32'h1234_5678, 32'h9abc_def0, hdr(0, 0)};
        run_stream(0, 1'b0);
        for (int k = 0; k < 3; k++) begin
            @(posedge clk); #1;
            n_cmp++;
            if (error !== 1'b1) begin
                n_bad++;
                $display("FAIL error_sticky cycle %0d: got %b expected 1", k, error);
            end
        end
        start_load();
        stim = '{hdr(0, 0)};
        run_stream(0, 1'b0);
    endtask

    task automatic test_overlong();
        start_load();
        stim = '{hdr(1, 5), 32'h1111_1111, 32'h2222_2222, 32'h3333_3333, 32'h4444_4444,
                 32'h5555_5555, hdr(1, 1), 32'h0000_00A5, hdr(0, 0)};
        run_stream(0, 1'b0);
        n_cmp++;
        if (error !== 1'b1) begin
            n_bad++;
            $display("FAIL overlong_error: got %b expected 1", error);
        end
    endtask

    task automatic test_gapped();
        start_load();
        stim.push_back(hdr(0, 4));
        for (int j = 0; j < 4; j++) stim.push_back($urandom);
        stim.push_back(hdr(1, 3));
        for (int j = 0; j < 3; j++) stim.push_back($urandom);
        stim.push_back(hdr(0, 0));
        run_stream(1, 1'b0);
    endtask

    task automatic test_reset_midload();
        logic [31:0] w1;
        start_load();
        w1 = $urandom;
        cfg_bus.cfg_in_valid = 1'b1;
        cfg_bus.cfg_in_data  = hdr(0, 2);
        @(posedge clk); #1;
        cfg_bus.cfg_in_data  = w1;
        @(posedge clk); #1;
        n_cmp++;
        if (pe_out[SLICE_W-1:0] !== {1'b1, w1}) begin
            n_bad++;
            $display("FAIL midload_pulse: got %h expected %h", pe_out[SLICE_W-1:0], {1'b1, w1});
        end
        #1 reset = 1'b0;
        #1;
        cfg_bus.cfg_in_valid = 1'b0;
        n_cmp++;
        if (pe_out !== '0 || cfg_bus.cfg_in_ready !== 1'b0 || busy !== 1'b0 || done !== 1'b0) begin
            n_bad++;
            $display("FAIL async_abort: out %h ready/busy/done %b%b%b expected 0 000",
                     pe_out, cfg_bus.cfg_in_ready, busy, done);
        end
        @(posedge clk); #1 reset = 1'b1;
        @(posedge clk); #1;
        start_load();
        stim = '{hdr(0, 0)};
        run_stream(0, 1'b0);
    endtask

    task automatic test_start_busy();
        start_load();
        push_random_program(3);
        run_stream(0, 1'b1);
    endtask

    task automatic test_random();
        for (int r = 0; r < 12; r++) begin
            start_load();
            push_random_program($urandom_range(1, 5));
            run_stream(2, 1'(r % 3 == 0));
            repeat ($urandom_range(0, 3)) @(posedge clk);
            #1;
        end
    endtask

    initial begin
        start = 1'b0;
        cfg_bus.cfg_in_valid = 1'b0;
        cfg_bus.cfg_in_data  = '0;
        m_left = 0; m_target = -1; m_err = 1'b0;
        test_reset();
        test_basic();
        test_bad_pe();
        test_overlong();
        test_gapped();
        test_reset_midload();
        test_start_busy();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached, expected completion");
        $fatal(1, "watchdog");
    end

endmodule
